gcd_result_tx: RTL and testbench
================================

Name: gcd_result_tx

Overview:
- Transmit-side companion to the GCD datapath. Accepts 7-bit GCD results with a valid strobe and buffers them in a small internal FIFO.
- Serialises each result off-chip as a UART 8N1 frame on a single line. This is the transmitter for the results the GCD top produces.
- Sits after the output FIFO of the GCD top and drives the board TX pin.

Parameters:
- DATA_W, 7, result width; the frame carries 8 data bits, bits above DATA_W are sent as 0.
- DEPTH, 4, internal buffer entries; power of two, 2..16.
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_data  input  DATA_W  result to transmit.
- i_data_valid  input  1  write strobe; one entry per cycle high.
- o_full  output  1  buffer holds DEPTH entries.
- o_empty  output  1  buffer holds 0 entries.
- o_busy  output  1  a frame is in progress (state != IDLE).
- o_tx  output  1  serial line, idle high.

Behaviour:
- Reset (async, immediate): o_tx=1, o_busy=0, o_empty=1, o_full=0, pointers/count=0, state=IDLE, bit/baud counters=0. Reset mid-frame aborts the frame; the line returns high at once. Buffered data is discarded.
- Write: when i_data_valid=1 and o_full=0 at a rising edge, i_data is stored. When o_full=1, the write is dropped silently, even if a pop occurs in the same cycle. o_full and o_empty are registered from count and update on the edge after the change.
- Pop: occurs only in IDLE with o_empty=0.
- Simultaneous write and pop: count unchanged.
- Write into an empty buffer: the entry is poppable from the next cycle; no bypass.
- Frame data: {zero pad, entry[DATA_W-1:0]} as 8 bits, sent LSB first.
- FSM states and transitions:
  - IDLE: o_tx=1. If o_empty=0 at an edge: pop the head into the shift register, go to START, o_tx<=0.
  - START: after CLKS_PER_BIT cycles, go to DATA and drive bit0.
  - DATA: each bit is held exactly CLKS_PER_BIT cycles, bit index 0..7. After bit7 go to STOP, o_tx<=1 (or to PARITY when enabled).
  - STOP: o_tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame length is 10*CLKS_PER_BIT cycles from the START entry edge to the IDLE entry edge.
- Back-to-back frames: IDLE lasts exactly one cycle between frames. Inter-frame line-high time is therefore CLKS_PER_BIT+1 cycles.
- Latency: a write to an idle, empty block gives a start-bit falling edge 2 cycles after the write edge.
- The baud counter wraps to 0 at CLKS_PER_BIT-1 and restarts on every state change.
- The pointers wrap modulo DEPTH.
- o_tx is driven straight from a register, so the output is glitch-free.

Optional Feature:
- Macro: GCD_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, making the frame 8E1. Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state; 8N1 frame of 10*CLKS_PER_BIT.

Test Plan:
- Reset check (CLKS_PER_BIT=4): rst high 3 cycles, then low -> o_tx=1, o_empty=1, o_full=0, o_busy=0.
- Single frame: write i_data=7'h15 once -> start edge 2 cycles later. Bits 1,0,1,0,1,0,0,0 LSB first, each held 4 cycles, then stop high. o_busy falls 40 cycles after START entry.
- Back-to-back frames: write 7'h06, 7'h03, 7'h7F on consecutive cycles -> three frames with exactly 5 high cycles between them. The third frame data byte is 8'h7F (bit7=0). o_empty=1 after the third pop.
- Overflow: with DEPTH=4 and the transmitter busy, write 6 values 1..6 -> o_full=1 after the 4th accept; 5 and 6 are dropped. Values 1..4 are transmitted in order.
- Async reset mid-frame: assert rst during DATA bit3 of 7'h2A -> o_tx=1 within the same cycle (before the next edge), buffer empty. A new write of 7'h01 after release transmits correctly.
- Parity build (GCD_TX_PARITY_EN, CLKS_PER_BIT=4): 7'h07 -> parity bit 1; 7'h03 -> parity bit 0. Frame length is 44 cycles.

Source files
------------

// File: rtl/gcd_result_tx.sv
// rtl/gcd_result_tx.sv - buffered UART transmitter for GCD results; define GCD_TX_PARITY_EN for 8E1 framing
module gcd_result_tx #(
   parameter int DATA_W       = 7,
   parameter int DEPTH        = 4,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_data_valid,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_busy,
   output logic              o_tx
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef GCD_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              full_r;
   logic              empty_r;
   logic              push;
   logic              pop;
   logic [7:0]        head_byte;

   state_t            state;
   state_t            state_n;
   logic [BW-1:0]     baud;
   logic [BW-1:0]     baud_n;
   logic              baud_last;
   logic [2:0]        bit_idx;
   logic [2:0]        bit_n;
   logic [7:0]        frame_r;
   logic              tx_r;
   logic              tx_n;

   // The count guard covers the cycle where count has reached DEPTH but full_r has not caught up yet.
   assign push      = i_data_valid && !full_r && (count != COUNT_FULL);
   assign baud_last = (baud == BAUD_LAST);

   // Head entry widened to a frame byte; bits above DATA_W are sent as zero.
   always_comb begin
      head_byte = '0;
      head_byte[DATA_W-1:0] = mem[rd_ptr];
   end

   // Buffer storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= i_data;
      end
   end

   // Pointers, occupancy and the status flags, which lag count by one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         full_r  <= 1'b0;
         empty_r <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         full_r  <= (count == COUNT_FULL);
         empty_r <= (count == '0);
      end
   end

   // Frame sequencing: next state, baud/bit counters and the next line level.
   always_comb begin
      state_n = state;
      baud_n  = baud + BW'(1);
      bit_n   = bit_idx;
      tx_n    = tx_r;
      pop     = 1'b0;
      case (state)
         S_IDLE: begin
            baud_n = '0;
            tx_n   = 1'b1;
            if (!empty_r) begin
               pop     = 1'b1;
               state_n = S_START;
               tx_n    = 1'b0;
            end
         end
         S_START: begin
            if (baud_last) begin
               state_n = S_DATA;
               baud_n  = '0;
               bit_n   = '0;
               tx_n    = frame_r[0];
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_n = '0;
               if (bit_idx == 3'd7) begin
`ifdef GCD_TX_PARITY_EN
                  state_n = S_PARITY;
                  tx_n    = ^frame_r;
`else
                  state_n = S_STOP;
                  tx_n    = 1'b1;
`endif
               end else begin
                  bit_n = bit_idx + 3'd1;
                  tx_n  = frame_r[bit_idx + 3'd1];
               end
            end
         end
`ifdef GCD_TX_PARITY_EN
         S_PARITY: begin
            if (baud_last) begin
               state_n = S_STOP;
               baud_n  = '0;
               tx_n    = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (baud_last) begin
               state_n = S_IDLE;
               baud_n  = '0;
               tx_n    = 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
            baud_n  = '0;
            tx_n    = 1'b1;
         end
      endcase
   end

   // State, counters and the line register; reset drives the line high immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         frame_r <= '0;
         tx_r    <= 1'b1;
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_n;
         tx_r    <= tx_n;
         if (pop) begin
            frame_r <= head_byte;
         end
      end
   end

   assign o_full  = full_r;
   assign o_empty = empty_r;
   assign o_busy  = (state != S_IDLE);
   assign o_tx    = tx_r;

endmodule

// File: tb/tb_gcd_result_tx.sv
// tb/tb_gcd_result_tx.sv - self-checking bench for gcd_result_tx with a frame-level model and UART receiver
module tb_gcd_result_tx;

   localparam int W = 7;
   localparam int D = 4;
   localparam int C = 4;
`ifdef GCD_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] i_data = '0;
   logic         i_data_valid = 1'b0;
   logic         o_full;
   logic         o_empty;
   logic         o_busy;
   logic         o_tx;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_wc = 0;

   gcd_result_tx #(.DATA_W(W), .DEPTH(D), .CLKS_PER_BIT(C)) dut (
      .clk(clk),
      .rst(rst),
      .i_data(i_data),
      .i_data_valid(i_data_valid),
      .o_full(o_full),
      .o_empty(o_empty),
      .o_busy(o_busy),
      .o_tx(o_tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // cycle counter
   always @(posedge clk) cyc++;

   // behavioural model: a queue of accepted results and a frame timer
   logic [7:0] mq[$];
   bit         m_full = 1'b0;
   bit         m_empty = 1'b1;
   int         ft = -1;
   int         fbits[11];
   bit         m_push;
   bit         m_pop;
   logic [7:0] m_byte;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_full = 1'b0;
         m_empty = 1'b1;
         ft = -1;
      end else begin
         m_push = i_data_valid && !m_full && (mq.size() < D);
         m_pop = (ft < 0) && !m_empty;
         m_full = (mq.size() == D);
         m_empty = (mq.size() == 0);
         if (m_pop) begin
            m_byte = mq.pop_front();
            fbits[0] = 0;
            for (int i = 0; i < 8; i++) fbits[1 + i] = int'(m_byte[i]);
            fbits[9] = (NB == 11) ? int'(^m_byte) : 1;
            fbits[10] = 1;
            ft = 0;
         end else if (ft >= 0) begin
            ft++;
            if (ft == NB * C) ft = -1;
         end
         if (m_push) mq.push_back({1'b0, i_data});
      end
   end

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (!rst) begin
         chk("model_tx", 32'(o_tx), (ft < 0) ? 32'd1 : 32'(fbits[ft / C]));
         chk("model_busy", 32'(o_busy), 32'(ft >= 0));
         chk("model_empty", 32'(o_empty), 32'(m_empty));
         chk("model_full", 32'(o_full), 32'(m_full));
      end
   end

   // line receiver: decodes frames at mid-bit and records timing
   logic [7:0] rx_q[$];
   int         fall_q[$];
   int         busy_q[$];
   logic       par_q[$];
   bit         rx_on = 1'b0;
   int         rx_t = 0;
   int         rx_k = 0;
   int         busy_run = 0;
   logic [7:0] rx_byte = '0;

   always @(negedge clk) begin
      if (rst) begin
         rx_on = 1'b0;
         busy_run = 0;
      end else begin
         if (o_busy === 1'b1) busy_run++;
         else if (busy_run > 0) begin
            busy_q.push_back(busy_run);
            busy_run = 0;
         end
         if (!rx_on) begin
            if (o_tx === 1'b0) begin
               rx_on = 1'b1;
               rx_t = 0;
               rx_byte = '0;
               fall_q.push_back(cyc);
            end
         end else begin
            rx_t++;
            if (rx_t % C == C / 2) begin
               rx_k = rx_t / C;
               if (rx_k == 0) chk("start_bit", 32'(o_tx), 32'd0);
               else if (rx_k <= 8) rx_byte[rx_k - 1] = o_tx;
               else if (rx_k == NB - 1) begin
                  chk("stop_bit", 32'(o_tx), 32'd1);
                  rx_q.push_back(rx_byte);
                  rx_on = 1'b0;
               end else par_q.push_back(o_tx);
            end
         end
      end
   end

   task automatic wr(input logic [W-1:0] d);
      @(posedge clk);
      #1;
      i_data = d;
      i_data_valid = 1'b1;
   endtask

   task automatic wr_end();
      @(posedge clk);
      #1;
      i_data_valid = 1'b0;
      last_wc = cyc;
   endtask

   task automatic wait_rx(input int n, input int budget);
      int k;
      k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (rx_q.size() < n) chk("rx_timeout", 32'(rx_q.size()), 32'(n));
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (!(o_busy === 1'b0 && o_empty === 1'b1) && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("idle_reached", 32'(o_busy), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic clear_rx();
      rx_q.delete();
      fall_q.delete();
      busy_q.delete();
      par_q.delete();
   endtask

   logic [7:0] exp_b2b[3] = '{8'h06, 8'h03, 8'h7F};
   logic [7:0] exp_ov[5]  = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04};
   int         k;

   initial begin
      // reset
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_tx", 32'(o_tx), 32'd1);
      chk("rst_empty", 32'(o_empty), 32'd1);
      chk("rst_full", 32'(o_full), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);

      // single frame
      clear_rx();
      wr(7'h15);
      wr_end();
      wait_rx(1, 200);
      if (rx_q.size() >= 1) chk("single_byte", 32'(rx_q[0]), 32'h15);
      if (fall_q.size() >= 1) chk("single_latency", 32'(fall_q[0] - last_wc), 32'd2);
      wait_idle();
      if (busy_q.size() >= 1) chk("single_busy_len", 32'(busy_q[0]), 32'(NB * C));

      // back-to-back
      clear_rx();
      wr(7'h06);
      wr(7'h03);
      wr(7'h7F);
      wr_end();
      wait_rx(3, 400);
      chk("b2b_empty", 32'(o_empty), 32'd1);
      for (int i = 0; i < 3; i++)
         if (rx_q.size() > i) chk("b2b_byte", 32'(rx_q[i]), 32'(exp_b2b[i]));
      for (int i = 1; i < 3; i++)
         if (fall_q.size() > i)
            chk("b2b_gap", 32'(fall_q[i] - fall_q[i - 1] - (NB - 1) * C), 32'(C + 1));
      wait_idle();

      // overflow
      clear_rx();
      wr(7'h55);
      wr_end();
      k = 0;
      while (o_busy !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("ov_busy", 32'(o_busy), 32'd1);
      for (int v = 1; v <= 6; v++) wr(W'(v));
      wr_end();
      @(negedge clk);
      chk("ov_full", 32'(o_full), 32'd1);
      chk("ov_not_empty", 32'(o_empty), 32'd0);
      wait_rx(5, 600);
      chk("ov_count", 32'(rx_q.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (rx_q.size() > i) chk("ov_byte", 32'(rx_q[i]), 32'(exp_ov[i]));
      wait_idle();

      // async reset during data bit3
      clear_rx();
      wr(7'h2A);
      wr_end();
      k = 0;
      while (o_busy !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      repeat (18) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("arst_tx", 32'(o_tx), 32'd1);
      chk("arst_busy", 32'(o_busy), 32'd0);
      chk("arst_empty", 32'(o_empty), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("arst_no_byte", 32'(rx_q.size()), 32'd0);
      wr(7'h01);
      wr_end();
      wait_rx(1, 200);
      if (rx_q.size() >= 1) chk("arst_new_byte", 32'(rx_q[0]), 32'h01);
      wait_idle();

`ifdef GCD_TX_PARITY_EN
      // parity framing
      clear_rx();
      wr(7'h07);
      wr(7'h03);
      wr_end();
      wait_rx(2, 400);
      if (par_q.size() >= 2) begin
         chk("par_07", 32'(par_q[0]), 32'd1);
         chk("par_03", 32'(par_q[1]), 32'd0);
      end else chk("par_count", 32'(par_q.size()), 32'd2);
      wait_idle();
      if (busy_q.size() >= 1) chk("par_busy_len", 32'(busy_q[0]), 32'd44);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
